// File: rtl/mul_unit_if.sv
// Decoder/writeback-facing signal bundle for the iterative MULTU unit.
// The slave side is the multiplier; the master side is the core driving it.
interface mul_unit_if #(
    parameter int WIDTH = 32
);
    logic             domul;
    logic             multoreg;
    logic             lohi;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] rdata;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             stall;

    modport slave (
        input  domul, multoreg, lohi, a, b,
        output rdata, hi, lo, busy, stall
    );

    modport master (
        output domul, multoreg, lohi, a, b,
        input  rdata, hi, lo, busy, stall
    );
endinterface

// File: rtl/mul_unit.sv
// Iterative shift-and-add unsigned multiplier with architectural HI/LO.
// One partial product per clock, fixed WIDTH-cycle run, result committed atomically.
module mul_unit #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       reset,
    mul_unit_if.slave  bus
);
    localparam int PW    = 2 * WIDTH;
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [PW-1:0]    acc_sum;
    logic             last;

    always_comb begin
        acc_sum  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
        last     = (cnt_q == CNT_W'(WIDTH - 1));
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            IDLE: begin
                // Operands are captured only here; a/b changes during RUN never reach the datapath.
                if (bus.domul) begin
                    state_d  = RUN;
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, bus.a};
                    mplier_d = bus.b;
                    cnt_d    = '0;
                end
            end
            RUN: begin
                acc_d    = acc_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_W'(1);
                if (last) begin
                    {hi_d, lo_d} = acc_sum;
                    state_d      = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

    // Any HI/LO consumer or new MULTU must wait while a product is in flight.
    assign bus.busy  = (state_q == RUN);
    assign bus.stall = bus.busy & (bus.domul | bus.multoreg);
    assign bus.rdata = bus.lohi ? hi_q : lo_q;
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule

// File: tb/tb_mul_unit.sv
// Directed bench for mul_unit: reset, products, stall/forwarding and abort behaviour.
module tb_mul_unit;
    localparam int WIDTH = 32;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    mul_unit_if #(.WIDTH(WIDTH)) bus ();

    mul_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse domul for one edge, then count edges until busy drops.
    task automatic run_mul(input logic [31:0] av, input logic [31:0] bv, output int lat);
        bus.a     = av;
        bus.b     = bv;
        bus.domul = 1'b1;
        tick();
        bus.domul = 1'b0;
        lat = 0;
        while (bus.busy && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int bad;
        int i;
        n_checks     = 0;
        n_pass       = 0;
        reset        = 1'b1;
        bus.domul    = 1'b0;
        bus.multoreg = 1'b0;
        bus.lohi     = 1'b0;
        bus.a        = '0;
        bus.b        = '0;

        // Reset
        repeat (2) tick();
        reset = 1'b0;
        check("rst_hi", 64'(bus.hi), 64'd0);
        check("rst_lo", 64'(bus.lo), 64'd0);
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_stall", 64'(bus.stall), 64'd0);
        check("rst_rdata", 64'(bus.rdata), 64'd0);

        // 3*5
        run_mul(32'd3, 32'd5, lat);
        check("m35_lat", 64'(lat), 64'd32);
        check("m35_lo", 64'(bus.lo), 64'd15);
        check("m35_hi", 64'(bus.hi), 64'd0);
        bus.multoreg = 1'b1;
        bus.lohi     = 1'b0;
        #1;
        check("m35_rdata", 64'(bus.rdata), 64'd15);
        check("m35_stall_idle", 64'(bus.stall), 64'd0);
        bus.multoreg = 1'b0;

        // All-ones squared
        run_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        check("mff_lat", 64'(lat), 64'd32);
        check("mff_hi", 64'(bus.hi), 64'hFFFF_FFFE);
        check("mff_lo", 64'(bus.lo), 64'h0000_0001);

        // MSB times two carries into HI
        run_mul(32'h8000_0000, 32'd2, lat);
        check("m80_hi", 64'(bus.hi), 64'd1);
        check("m80_lo", 64'(bus.lo), 64'd0);
        bus.lohi = 1'b1;
        #1;
        check("m80_rdata_hi", 64'(bus.rdata), 64'd1);
        bus.lohi = 1'b0;

        // MFLO during RUN stalls and sees the old value until completion
        run_mul(32'd3, 32'd5, lat);
        bus.a     = 32'd2;
        bus.b     = 32'd3;
        bus.domul = 1'b1;
        tick();
        bus.domul = 1'b0;
        bus.a     = 32'd1000;
        bus.b     = 32'd1000;
        repeat (4) tick();
        bus.multoreg = 1'b1;
        bus.lohi     = 1'b0;
        #1;
        bad = 0;
        i   = 4;
        while (bus.busy && i < 100) begin
            if (bus.stall !== 1'b1 || bus.rdata !== 32'd15) bad++;
            tick();
            i++;
        end
        check("mfl_hold_bad", 64'(bad), 64'd0);
        check("mfl_edges", 64'(i), 64'd32);
        check("mfl_stall_done", 64'(bus.stall), 64'd0);
        check("mfl_rdata_done", 64'(bus.rdata), 64'd6);
        bus.multoreg = 1'b0;

        // domul held for 40 cycles: back-to-back multiplies 33 edges apart
        bus.a     = 32'd4;
        bus.b     = 32'd4;
        bus.domul = 1'b1;
        tick();
        check("b2b_busy_k", 64'(bus.busy), 64'd1);
        bad = 0;
        for (int e = 1; e < 40; e++) begin
            tick();
            if (bus.busy !== ((e == 32) ? 1'b0 : 1'b1)) bad++;
            if (bus.stall !== bus.busy) bad++;
            if (e == 32) begin
                check("b2b_first_lo", 64'(bus.lo), 64'd16);
                check("b2b_first_hi", 64'(bus.hi), 64'd0);
            end
        end
        check("b2b_seq_bad", 64'(bad), 64'd0);
        bus.domul = 1'b0;
        i = 39;
        while (bus.busy && i < 200) begin
            tick();
            i++;
        end
        check("b2b_second_done", 64'(i), 64'd65);
        check("b2b_second_lo", 64'(bus.lo), 64'd16);

        // Reset mid-run aborts without residue
        bus.a     = 32'd7;
        bus.b     = 32'd9;
        bus.domul = 1'b1;
        tick();
        bus.domul = 1'b0;
        repeat (9) tick();
        check("abt_lo_held", 64'(bus.lo), 64'd16);
        check("abt_busy_pre", 64'(bus.busy), 64'd1);
        reset     = 1'b1;
        bus.domul = 1'b1;
        tick();
        reset = 1'b0;
        check("abt_busy", 64'(bus.busy), 64'd0);
        check("abt_stall", 64'(bus.stall), 64'd0);
        check("abt_hi", 64'(bus.hi), 64'd0);
        check("abt_lo", 64'(bus.lo), 64'd0);
        bus.domul = 1'b0;
        run_mul(32'd7, 32'd9, lat);
        check("abt_new_lat", 64'(lat), 64'd32);
        check("abt_new_lo", 64'(bus.lo), 64'd63);
        check("abt_new_hi", 64'(bus.hi), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
